// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/transmit controllers.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic [15:0] DIV_MIN     = 16'd2;
    localparam logic [4:0]  OVS_MIN     = 5'd4;
    localparam logic [1:0]  PRIME_TICKS = 2'd2;
    localparam logic [15:0] DEFAULT_DIV = 16'd27;
    localparam logic [4:0]  DEFAULT_OVS = 5'd16;

    // The tick generator needs at least two clk cycles per half period.
    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < DIV_MIN) ? DIV_MIN : div;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through byte FIFO with wrap-bit pointers; shared by the RX and TX controllers.
module uart_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        wr_en;
    logic        rd_en;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rd_en = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push && (!full || rd_en);
    assign rdata = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_d = wr_q;
        rd_d = rd_q;
        if (wr_en) wr_d = wr_q + PTR_ONE;
        if (rd_en) rd_d = rd_q + PTR_ONE;
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: tick generation, priming sequence, byte capture FIFO, overrun.
// Optional idle timeout is built when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int          DEPTH   = 4,
    parameter logic [15:0] DIV_RST = DEFAULT_DIV,
    parameter logic [4:0]  OVS_RST = DEFAULT_OVS
`ifdef UART_RX_CTRL_TIMEOUT_EN
   ,parameter int          TIMEOUT_TICKS = 64
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        cfg_load,
    input  logic [15:0] cfg_div,
    input  logic [4:0]  cfg_ovs,
    output logic        s_tick,
    output logic        rx_reset,
    output logic [4:0]  oversampling,
    input  logic        rx_done,
    input  logic [7:0]  rx_dout,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        overrun,
    input  logic        ovr_clr,
    output logic [1:0]  state_o,
    output logic        rx_timeout
);

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  ovs_q, ovs_d;
    logic [1:0]  prime_q, prime_d;
    logic        tick_q, tick_d;
    logic        rx_reset_q, rx_reset_d;
    logic        push_q, push_d;
    logic        overrun_q, overrun_d;
    logic        sync1_q, sync2_q, done_prev_q;
    logic        tick_rise;
    logic        fifo_full, fifo_empty, pop;

    assign m_valid      = !fifo_empty;
    assign pop          = m_valid && m_ready;
    assign s_tick       = tick_q;
    assign rx_reset     = rx_reset_q;
    assign oversampling = ovs_q;
    assign overrun      = overrun_q;
    assign state_o      = state_q;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        ovs_d     = ovs_q;
        cnt_d     = cnt_q;
        tick_d    = tick_q;
        prime_d   = prime_q;
        overrun_d = overrun_q;
        tick_rise = 1'b0;

        if (cfg_load && state_q == ST_OFF) begin
            div_d = clamp_div(cfg_div);
            if (cfg_ovs >= OVS_MIN) ovs_d = cfg_ovs;
        end

        if (state_q == ST_OFF || !enable) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (cnt_q == div_q - 16'd1) begin
            cnt_d     = '0;
            tick_d    = !tick_q;
            tick_rise = !tick_q;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        case (state_q)
            ST_OFF: begin
                prime_d = '0;
                if (enable) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (tick_rise) prime_d = prime_q + 2'd1;
                // Leave one clk after the last priming edge so the receiver sees reset on both edges.
                if (prime_q == PRIME_TICKS) state_d = ST_RUN;
            end
            ST_RUN:  ;
            default: state_d = ST_OFF;
        endcase
        if (!enable) state_d = ST_OFF;

        rx_reset_d = (state_d != ST_RUN);
        push_d     = sync2_q && !done_prev_q && (state_q == ST_RUN);

        if (ovr_clr) overrun_d = 1'b0;
        if (push_q && fifo_full && !pop) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_OFF;
            div_q       <= DIV_RST;
            ovs_q       <= OVS_RST;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            prime_q     <= '0;
            rx_reset_q  <= 1'b1;
            push_q      <= 1'b0;
            overrun_q   <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            ovs_q       <= ovs_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            prime_q     <= prime_d;
            rx_reset_q  <= rx_reset_d;
            push_q      <= push_d;
            overrun_q   <= overrun_d;
            sync1_q     <= rx_done;
            sync2_q     <= sync1_q;
            done_prev_q <= sync2_q;
        end
    end

    // rx_dout is sampled straight from the pin; it stays stable while rx_done is high.
    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .wdata (rx_dout),
        .pop   (pop),
        .rdata (m_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_flag_q;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (push_q || fifo_empty || state_q != ST_RUN) begin
            to_cnt_d = '0;
        end else if (tick_rise && to_cnt_q != TW'(TIMEOUT_TICKS)) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= (to_cnt_d == TW'(TIMEOUT_TICKS));
        end
    end

    assign rx_timeout = to_flag_q;
`else
    assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed sequence, random payloads, queue-based FIFO model.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, enable, cfg_load;
    logic [15:0] cfg_div;
    logic [4:0]  cfg_ovs;
    logic        s_tick, rx_reset;
    logic [4:0]  oversampling;
    logic        rx_done;
    logic [7:0]  rx_dout;
    logic [7:0]  m_data;
    logic        m_valid, m_ready;
    logic        overrun, ovr_clr;
    logic [1:0]  state_o;
    logic        rx_timeout;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  model_q [$];
    logic        exp_ovr;

    uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cfg_load     (cfg_load),
        .cfg_div      (cfg_div),
        .cfg_ovs      (cfg_ovs),
        .s_tick       (s_tick),
        .rx_reset     (rx_reset),
        .oversampling (oversampling),
        .rx_done      (rx_done),
        .rx_dout      (rx_dout),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .overrun      (overrun),
        .ovr_clr      (ovr_clr),
        .state_o      (state_o),
        .rx_timeout   (rx_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_head();
        return (model_q.size() != 0) ? model_q[0] : 8'h00;
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else exp_ovr = 1'b1;
    endfunction

    task automatic check_fifo(input string tag);
        check({tag, "_valid"}, m_valid, model_q.size() != 0);
        check({tag, "_data"}, m_data, model_head());
        check({tag, "_ovr"}, overrun, exp_ovr);
    endtask

    // Frame-done pulse: high long enough to be captured, low long enough to re-arm the edge detector.
    task automatic send_byte(input logic [7:0] b, input bit captured);
        rx_dout = b;
        rx_done = 1'b1;
        step(6);
        rx_done = 1'b0;
        step(4);
        if (captured) model_push(b);
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (model_q.size() != 0 && guard < 2 * DEPTH) begin
            check({tag, "_order"}, m_data, model_head());
            pop_one();
            guard++;
        end
        check({tag, "_empty"}, m_valid, 1'b0);
    endtask

    task automatic prime_check(input string tag);
        int   n = 0;
        int   rises = 0;
        int   rst_bad = 0;
        logic prev;
        enable = 1'b1;
        prev   = s_tick;
        step(1);
        check({tag, "_state_prime"}, state_o, 2'd1);
        while (state_o == 2'd1 && n < 400) begin
            if (s_tick && !prev) rises++;
            if (!rx_reset) rst_bad++;
            prev = s_tick;
            step(1);
            n++;
        end
        check({tag, "_state_run"}, state_o, 2'd2);
        check({tag, "_prime_edges"}, rises, 2);
        check({tag, "_rst_in_prime"}, rst_bad, 0);
        check({tag, "_rst_in_run"}, rx_reset, 1'b0);
    endtask

    task automatic measure(output int per, output int hi);
        int   n = 0;
        logic prev = s_tick;
        while (!(s_tick && !prev) && n < 200) begin
            prev = s_tick;
            step(1);
            n++;
        end
        n = 0;
        while (s_tick && n < 200) begin
            step(1);
            n++;
        end
        hi = n;
        while (!s_tick && n < 200) begin
            step(1);
            n++;
        end
        per = n;
    endtask

    initial begin
        int         per, hi, n, rises;
        logic       prev;
        logic [7:0] b;

        reset = 1'b1; enable = 1'b0; cfg_load = 1'b0; cfg_div = '0; cfg_ovs = '0;
        rx_done = 1'b0; rx_dout = '0; m_ready = 1'b0; ovr_clr = 1'b0; exp_ovr = 1'b0;
        step(3);
        check("rst_state", state_o, 2'd0);
        check("rst_tick", s_tick, 1'b0);
        check("rst_rxrst", rx_reset, 1'b1);
        check("rst_ovs", oversampling, 5'd16);
        check("rst_valid", m_valid, 1'b0);
        check("rst_data", m_data, 8'h00);
        check("rst_ovr", overrun, 1'b0);
        check("rst_timeout", rx_timeout, 1'b0);
        reset = 1'b0;
        step(1);

        // div = 4 -> s_tick period 8 clk
        cfg_div = 16'd4; cfg_ovs = 5'd16; cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
        prime_check("prime1");
        measure(per, hi);
        check("period_div4", per, 8);
        check("high_div4", hi, 4);

        // Single byte: m_valid rises on the fourth clk after the pin edge.
        rx_dout = 8'hA5; rx_done = 1'b1;
        step(3);
        check("lat_not_yet", m_valid, 1'b0);
        step(1);
        check("lat_valid", m_valid, 1'b1);
        check("lat_data", m_data, 8'hA5);
        step(2);
        rx_done = 1'b0;
        step(4);
        model_push(8'hA5);
        pop_one();
        check("pop_a5", m_valid, 1'b0);

        // Overflow: five bytes into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        check_fifo("ovf");
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        exp_ovr = 1'b0;
        check("ovr_clr", overrun, 1'b0);
        drain("ovf_drain");
        m_ready = 1'b1;
        step(2);
        m_ready = 1'b0;
        check("empty_ready_valid", m_valid, 1'b0);
        check("empty_ready_data", m_data, 8'h00);

        // Full FIFO with push and pop on the same edge.
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        check("full_cnt", model_q.size(), DEPTH);
        rx_dout = 8'h05; rx_done = 1'b1;
        step(3);
        m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
        void'(model_q.pop_front());
        model_push(8'h05);
        step(2);
        rx_done = 1'b0;
        step(4);
        check_fifo("simul");
        drain("simul_drain");

        // Random payloads with random consumer pops.
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1);
            check_fifo("rand");
            if ($urandom_range(0, 1) == 1) pop_one();
        end
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        exp_ovr = 1'b0;
        drain("rand_drain");

        // Configuration is ignored outside OFF.
        cfg_div = 16'd10; cfg_ovs = 5'd8; cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
        step(1);
        check("run_cfg_ovs", oversampling, 5'd16);
        measure(per, hi);
        check("run_cfg_period", per, 8);

        // Disable keeps FIFO contents; edges while OFF are discarded.
        send_byte(8'h77, 1'b1);
        enable = 1'b0;
        step(1);
        check("off_state", state_o, 2'd0);
        check("off_tick", s_tick, 1'b0);
        check("off_rxrst", rx_reset, 1'b1);
        check_fifo("off_keep");
        send_byte(8'h3C, 1'b0);
        check_fifo("off_discard");
        drain("off_drain");

        // Clamp div to 2, reject ovs < 4; then a legal ovs.
        cfg_div = 16'd1; cfg_ovs = 5'd3; cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
        check("ovs_reject", oversampling, 5'd16);
        cfg_ovs = 5'd8; cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
        check("ovs_accept", oversampling, 5'd8);
        prime_check("prime2");
        measure(per, hi);
        check("period_div2", per, 4);
        check("high_div2", hi, 2);

        // Idle timeout on an unread byte.
        rx_dout = 8'($urandom); rx_done = 1'b1;
        n = 0;
        while (!m_valid && n < 20) begin
            step(1);
            n++;
        end
        check("to_push", m_valid, 1'b1);
        model_push(rx_dout);
        rx_done = 1'b0;
        prev = s_tick;
        rises = 0;
        n = 0;
        while (n < 600) begin
            step(1);
            n++;
            if (s_tick && !prev) rises++;
            prev = s_tick;
`ifdef UART_RX_CTRL_TIMEOUT_EN
            if (rx_timeout) break;
`endif
        end
`ifdef UART_RX_CTRL_TIMEOUT_EN
        check("to_assert", rx_timeout, 1'b1);
        check("to_edges", rises, 64);
        pop_one();
        step(1);
        check("to_release", rx_timeout, 1'b0);
`else
        check("to_tied_low", rx_timeout, 1'b0);
        pop_one();
`endif

        // Reset in mid-operation.
        send_byte(8'h5A, 1'b1);
        check("pre_reset_valid", m_valid, 1'b1);
        reset = 1'b1;
        step(1);
        model_q.delete();
        exp_ovr = 1'b0;
        check("mid_rst_state", state_o, 2'd0);
        check("mid_rst_rxrst", rx_reset, 1'b1);
        check("mid_rst_tick", s_tick, 1'b0);
        check("mid_rst_ovs", oversampling, 5'd16);
        check_fifo("mid_rst");
        reset = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
